// File: rtl/router_pkt_reg_if.sv
// Bundle between the router input port, the packet register stage and the
// selected channel FIFO.
interface router_pkt_reg_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    // Handshake: the source presents pkt_valid/data_in. A beat is taken on
    // every rising edge where busy is low, and the source must hold both
    // unchanged while busy is high. On the FIFO side, dout is written on
    // each cycle with dout_valid high. fifo_full is sampled at the same edge
    // that schedules that write.
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic              fifo_full;
    logic              busy;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [ADDR_W-1:0] dout_ch;
    logic              parity_done;
    logic              err;
    logic              len_err;
    logic              drop_pkt;

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        output busy, dout, dout_valid, dout_ch, parity_done, err, len_err, drop_pkt
    );

    modport master (
        output pkt_valid, data_in, fifo_full,
        input  busy, dout, dout_valid, dout_ch, parity_done, err, len_err, drop_pkt
    );
endinterface

// File: rtl/router_pkt_reg.sv
// Packet register stage: validates the header, streams the packet to the selected
// FIFO through a small holding buffer, and checks the parity and length.
module router_pkt_reg #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 2,
    parameter int NUM_CH      = 3,
    parameter int HOLD_DEPTH  = 2,
    parameter int PARITY_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    router_pkt_reg_if.slave  bus,
    output logic [2:0]       state_dbg
);
    localparam int LEN_W = DATA_W - ADDR_W;
    localparam int CW    = $clog2(HOLD_DEPTH + 1);
    localparam logic [CW-1:0]     DEPTH_C  = CW'(HOLD_DEPTH);
    localparam logic [ADDR_W:0]   NUM_CH_C = (ADDR_W + 1)'(NUM_CH);
    localparam logic [LEN_W-1:0]  LEN_MAX  = '1;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, CHECK, DROP} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] hold [HOLD_DEPTH];
    logic [CW-1:0]     count, count_n, widx;
    logic [LEN_W-1:0]  len, beats;
    logic [DATA_W-1:0] calc, rx, folded;
    logic [ADDR_W-1:0] hdr_dest;
    logic [LEN_W-1:0]  hdr_len;
    logic              accept, route, direct, push, pop, dest_ok;

    assign state_dbg = state;

    always_comb begin
        hdr_dest = bus.data_in[ADDR_W-1:0];
        hdr_len  = bus.data_in[DATA_W-1:ADDR_W];
        dest_ok  = {1'b0, hdr_dest} < NUM_CH_C;
        accept   = !bus.busy && ((state == IDLE && bus.pkt_valid) || state == LOAD || state == DROP);
        route    = accept && ((state == IDLE && dest_ok) || state == LOAD);
        pop      = !bus.fifo_full && (count != '0);
        direct   = route && !bus.fifo_full && (count == '0);
        push     = route && !direct;
        count_n  = count + CW'(push) - CW'(pop);
        widx     = count - CW'(pop);
        folded   = (PARITY_MODE == 1) ? calc + bus.data_in : calc ^ bus.data_in;

        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = dest_ok ? LOAD : DROP;
            LOAD:    if (accept && !bus.pkt_valid) state_n = DRAIN;
            DRAIN:   if (count_n == '0) state_n = CHECK;
            CHECK:   state_n = IDLE;
            DROP:    if (accept && !bus.pkt_valid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            len             <= '0;
            beats           <= '0;
            calc            <= '0;
            rx              <= '0;
            bus.busy        <= 1'b0;
            bus.dout        <= '0;
            bus.dout_valid  <= 1'b0;
            bus.dout_ch     <= '0;
            bus.parity_done <= 1'b0;
            bus.err         <= 1'b0;
            bus.len_err     <= 1'b0;
            bus.drop_pkt    <= 1'b0;
        end else begin
            state          <= state_n;
            count          <= count_n;
            bus.dout_valid <= pop || direct;
            // The oldest buffered beat always goes out before a newly routed one.
            if (pop)
                bus.dout <= hold[0];
            else if (direct)
                bus.dout <= bus.data_in;
            bus.busy        <= (state_n == DRAIN) || (state_n == CHECK) || (count_n == DEPTH_C);
            bus.parity_done <= (state == DRAIN) && (state_n == CHECK);
            bus.err         <= (state == DRAIN) && (state_n == CHECK) && (calc != rx);
            bus.len_err     <= (state == DRAIN) && (state_n == CHECK) && (beats != len);
            bus.drop_pkt    <= (state == DROP) && (state_n == IDLE);

            if (state == IDLE && accept) begin
                bus.dout_ch <= hdr_dest;
                len         <= hdr_len;
                calc        <= bus.data_in;
                beats       <= '0;
            end
            if (state == LOAD && accept) begin
                if (bus.pkt_valid) begin
                    calc <= folded;
                    if (beats != LEN_MAX)
                        beats <= beats + 1'b1;
                end else begin
                    rx <= bus.data_in;
                end
            end
        end
    end

    // Holding buffer data needs no reset; count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (pop)
            for (int i = 0; i < HOLD_DEPTH - 1; i++)
                hold[i] <= hold[i + 1];
        if (push)
            hold[widx] <= bus.data_in;
    end
endmodule
